// File: rtl/line_fill_responder_pkg.sv
// Shared types and helpers for the line-fill responder.
// Macro LINE_FILL_CWF_EN selects critical-word-first beat ordering.
package line_fill_pkg;

   localparam int LINE_WORDS = 4;
   localparam int OFF_W      = 2;
   localparam int LAT_W      = 4;

   typedef enum logic [2:0] {
      LF_IDLE   = 3'd0,
      LF_WAIT   = 3'd1,
      LF_RBURST = 3'd2,
      LF_WBURST = 3'd3,
      LF_DONE   = 3'd4
   } lf_state_t;

`ifdef LINE_FILL_CWF_EN
   localparam bit CWF_EN = 1'b1;
`else
   localparam bit CWF_EN = 1'b0;
`endif

   // Word offset of beat b; wraps inside the line so the base never moves.
   function automatic logic [OFF_W-1:0] beat_off(input logic [OFF_W-1:0] start,
                                                 input logic [OFF_W-1:0] b);
      return CWF_EN ? OFF_W'(start + b) : b;
   endfunction

endpackage

// File: rtl/line_fill_responder_if.sv
// Cache-to-memory line-fill bus; master is the cache controller, slave the responder.
// Requests are levels; ready_mem qualifies each of the four beats.
interface line_fill_responder_if #(
   parameter int AWIDTH = 9,
   parameter int DWIDTH = 8
);
   logic              rd_mem;
   logic              wr_mem;
   logic [AWIDTH-1:0] addr_mem;
   logic [DWIDTH-1:0] wdata_mem;
   logic [DWIDTH-1:0] rdata_mem;
   logic              rdata_oe;
   logic              ready_mem;
   logic              busy;

   modport master (
      output rd_mem, wr_mem, addr_mem, wdata_mem,
      input  rdata_mem, rdata_oe, ready_mem, busy
   );

   modport slave (
      input  rd_mem, wr_mem, addr_mem, wdata_mem,
      output rdata_mem, rdata_oe, ready_mem, busy
   );
endinterface

// File: rtl/line_fill_responder_mem_array.sv
// Single-port word array: synchronous write, combinational read, no reset.
// Contents survive responder reset; the caller registers the read data.
module lf_mem_array #(
   parameter int AWIDTH = 9,
   parameter int DWIDTH = 8
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [AWIDTH-1:0] i_addr,
   input  logic [DWIDTH-1:0] i_wdata,
   output logic [DWIDTH-1:0] o_rdata
);
   logic [DWIDTH-1:0] r_mem [0:(1<<AWIDTH)-1];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/line_fill_responder.sv
// Memory-side line-fill/write-back responder: MEM_LATENCY wait cycles, then a 4-beat burst.
// Registered outputs only; beat order comes from line_fill_pkg::beat_off (LINE_FILL_CWF_EN).
module line_fill_responder
   import line_fill_pkg::*;
#(
   parameter int AWIDTH      = 9,
   parameter int DWIDTH      = 8,
   parameter int MEM_LATENCY = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   line_fill_responder_if.slave  bus
);
   localparam int                BASE_W    = AWIDTH - OFF_W;
   localparam logic [OFF_W-1:0]  LAST_BEAT = OFF_W'(LINE_WORDS - 1);
   localparam logic [LAT_W-1:0]  LAT_LOAD  = (MEM_LATENCY == 0) ? '0 : LAT_W'(MEM_LATENCY - 1);

   lf_state_t          r_state, w_state_n;
   logic [LAT_W-1:0]   r_cnt, w_cnt_n;
   logic [OFF_W-1:0]   r_beat, w_beat_n;
   logic [OFF_W-1:0]   r_start, w_start_n;
   logic [BASE_W-1:0]  r_base, w_base_n;
   logic               r_wr, w_wr_n;
   logic [DWIDTH-1:0]  r_rdata;
   logic               r_oe;
   logic               r_ready;
   logic               r_busy;

   logic               w_burst_n;
   logic               w_mem_we;
   logic [AWIDTH-1:0]  w_mem_addr;
   logic [DWIDTH-1:0]  w_mem_rdata;

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_beat_n  = r_beat;
      w_base_n  = r_base;
      w_start_n = r_start;
      w_wr_n    = r_wr;
      case (r_state)
         LF_IDLE: begin
            if (bus.wr_mem || bus.rd_mem) begin
               w_base_n  = bus.addr_mem[AWIDTH-1:OFF_W];
               w_start_n = bus.addr_mem[OFF_W-1:0];
               w_wr_n    = bus.wr_mem;
               w_beat_n  = '0;
               w_cnt_n   = LAT_LOAD;
               if (MEM_LATENCY == 0) begin
                  w_state_n = bus.wr_mem ? LF_WBURST : LF_RBURST;
               end else begin
                  w_state_n = LF_WAIT;
               end
            end
         end
         LF_WAIT: begin
            if (r_cnt == '0) begin
               w_state_n = r_wr ? LF_WBURST : LF_RBURST;
               w_beat_n  = '0;
            end else begin
               w_cnt_n = r_cnt - 1'b1;
            end
         end
         LF_RBURST, LF_WBURST: begin
            if (r_beat == LAST_BEAT) begin
               w_state_n = LF_DONE;
            end else begin
               w_beat_n = r_beat + 1'b1;
            end
         end
         LF_DONE: w_state_n = LF_IDLE;
         default: w_state_n = LF_IDLE;
      endcase
   end

   // Writes use the beat in flight; reads look up the beat about to be presented.
   assign w_burst_n  = (w_state_n == LF_RBURST) || (w_state_n == LF_WBURST);
   assign w_mem_we   = (r_state == LF_WBURST);
   assign w_mem_addr = w_mem_we ? {r_base, beat_off(r_start, r_beat)}
                                : {w_base_n, beat_off(w_start_n, w_beat_n)};

   lf_mem_array #(
      .AWIDTH (AWIDTH),
      .DWIDTH (DWIDTH)
   ) u_mem (
      .i_clk   (clock),
      .i_we    (w_mem_we),
      .i_addr  (w_mem_addr),
      .i_wdata (bus.wdata_mem),
      .o_rdata (w_mem_rdata)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= LF_IDLE;
         r_cnt   <= '0;
         r_beat  <= '0;
         r_start <= '0;
         r_base  <= '0;
         r_wr    <= 1'b0;
         r_rdata <= '0;
         r_oe    <= 1'b0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_beat  <= w_beat_n;
         r_start <= w_start_n;
         r_base  <= w_base_n;
         r_wr    <= w_wr_n;
         r_rdata <= (w_state_n == LF_RBURST) ? w_mem_rdata : '0;
         r_oe    <= (w_state_n == LF_RBURST);
         r_ready <= w_burst_n;
         r_busy  <= (w_state_n != LF_IDLE);
      end
   end

   assign bus.rdata_mem = r_rdata;
   assign bus.rdata_oe  = r_oe;
   assign bus.ready_mem = r_ready;
   assign bus.busy      = r_busy;
endmodule

// File: tb/tb_line_fill_responder.sv
// Directed bench for line_fill_responder: one instance at latency 2, one at latency 0.
// Expected read beats come from a shadow memory model through per-instance queues.
module tb_line_fill_responder;
   localparam int LAT_A = 2;
   localparam int LAT_B = 0;
`ifdef LINE_FILL_CWF_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   int         checks  = 0;
   int         errors  = 0;
   logic [7:0] model [2][512];
   logic [7:0] q_a [$];
   logic [7:0] q_b [$];

   always #5 clock = ~clock;

   line_fill_responder_if #(.AWIDTH(9), .DWIDTH(8)) ifa ();
   line_fill_responder_if #(.AWIDTH(9), .DWIDTH(8)) ifb ();

   line_fill_responder #(.AWIDTH(9), .DWIDTH(8), .MEM_LATENCY(LAT_A)) dut_a (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (ifa.slave)
   );

   line_fill_responder #(.AWIDTH(9), .DWIDTH(8), .MEM_LATENCY(LAT_B)) dut_b (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (ifb.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] beat_addr(input logic [8:0] a, input int k);
      logic [1:0] o;
      o = CWF ? 2'(a[1:0] + k) : 2'(k);
      return {a[8:2], o};
   endfunction

   task automatic set_req(input bit s, input logic rd, input logic wr, input logic [8:0] a);
      if (s) begin
         ifb.rd_mem = rd; ifb.wr_mem = wr; ifb.addr_mem = a;
      end else begin
         ifa.rd_mem = rd; ifa.wr_mem = wr; ifa.addr_mem = a;
      end
   endtask

   task automatic set_wdata(input bit s, input logic [7:0] d);
      if (s) ifb.wdata_mem = d;
      else   ifa.wdata_mem = d;
   endtask

   task automatic check_outs(input bit s, input string tag,
                             input logic ready, input logic oe, input logic busy);
      if (s) begin
         chk({tag, "_ready"}, 32'(ifb.ready_mem), 32'(ready));
         chk({tag, "_oe"},    32'(ifb.rdata_oe),  32'(oe));
         chk({tag, "_busy"},  32'(ifb.busy),      32'(busy));
      end else begin
         chk({tag, "_ready"}, 32'(ifa.ready_mem), 32'(ready));
         chk({tag, "_oe"},    32'(ifa.rdata_oe),  32'(oe));
         chk({tag, "_busy"},  32'(ifa.busy),      32'(busy));
      end
   endtask

   // One full transaction; starts and ends on a falling edge.
   task automatic txn(input bit s, input logic rd, input logic wr, input logic [8:0] a,
                      input logic [31:0] wd, input bit hold, input string tag);
      int lat;
      lat = s ? LAT_B : LAT_A;
      set_req(s, rd, wr, a);
      @(posedge clock);
      for (int k = 0; k < 4; k++) begin
         if (wr)     model[s][beat_addr(a, k)] = wd[8*k +: 8];
         else if (s) q_b.push_back(model[1][beat_addr(a, k)]);
         else        q_a.push_back(model[0][beat_addr(a, k)]);
      end
      for (int j = 0; j <= lat + 5; j++) begin
         @(negedge clock);
         if (!hold) set_req(s, 1'b0, 1'b0, ~a);
         if (wr && j >= lat && j <= lat + 3) set_wdata(s, wd[8*(j-lat) +: 8]);
         else                               set_wdata(s, 8'h5A);
         check_outs(s, tag, (j >= lat && j <= lat + 3),
                    (!wr && j >= lat && j <= lat + 3), (j <= lat + 4));
      end
   endtask

   always @(negedge clock) begin
      if (ifa.rdata_oe === 1'b1) begin
         if (q_a.size() == 0) chk("a_extra_beat", 32'(q_a.size()), 32'd1);
         else                 chk("a_rdata", 32'(ifa.rdata_mem), 32'(q_a.pop_front()));
      end
      if (ifb.rdata_oe === 1'b1) begin
         if (q_b.size() == 0) chk("b_extra_beat", 32'(q_b.size()), 32'd1);
         else                 chk("b_rdata", 32'(ifb.rdata_mem), 32'(q_b.pop_front()));
      end
   end

   initial begin
      set_req(1'b0, 1'b0, 1'b0, 9'h000);
      set_req(1'b1, 1'b0, 1'b0, 9'h000);
      set_wdata(1'b0, 8'h00);
      set_wdata(1'b1, 8'h00);
      #12;
      check_outs(1'b0, "a_reset", 1'b0, 1'b0, 1'b0);
      check_outs(1'b1, "b_reset", 1'b0, 1'b0, 1'b0);
      chk("a_reset_rdata", 32'(ifa.rdata_mem), 32'h0);
      chk("b_reset_rdata", 32'(ifb.rdata_mem), 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      txn(1'b0, 1'b0, 1'b1, 9'h024, 32'hA3A2A1A0, 1'b0, "a_wr_024");
      txn(1'b0, 1'b1, 1'b0, 9'h025, 32'h0,        1'b0, "a_rd_025");
      txn(1'b0, 1'b1, 1'b1, 9'h040, 32'hB3B2B1B0, 1'b0, "a_both_040");
      txn(1'b0, 1'b1, 1'b0, 9'h042, 32'h0,        1'b0, "a_rd_042");
      txn(1'b0, 1'b1, 1'b0, 9'h026, 32'h0,        1'b1, "a_rd_held");
      txn(1'b0, 1'b1, 1'b0, 9'h041, 32'h0,        1'b0, "a_rd_back2back");

      // Reset while beat 1 of a read is on the bus.
      set_req(1'b0, 1'b1, 1'b0, 9'h024);
      @(posedge clock);
      q_a.push_back(model[0][beat_addr(9'h024, 0)]);
      q_a.push_back(model[0][beat_addr(9'h024, 1)]);
      @(negedge clock);
      set_req(1'b0, 1'b0, 1'b0, 9'h000);
      repeat (3) @(negedge clock);
      check_outs(1'b0, "a_pre_rst", 1'b1, 1'b1, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      check_outs(1'b0, "a_mid_rst", 1'b0, 1'b0, 1'b0);
      chk("a_mid_rst_rdata", 32'(ifa.rdata_mem), 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check_outs(1'b0, "a_post_rst", 1'b0, 1'b0, 1'b0);
      chk("a_post_rst_queue", 32'(q_a.size()), 32'd0);
      txn(1'b0, 1'b1, 1'b0, 9'h024, 32'h0, 1'b0, "a_rd_after_rst");

      txn(1'b1, 1'b0, 1'b1, 9'h1FC, 32'hC3C2C1C0, 1'b0, "b_wr_1fc");
      txn(1'b1, 1'b0, 1'b1, 9'h1F8, 32'hD3D2D1D0, 1'b0, "b_wr_1f8");
      txn(1'b1, 1'b0, 1'b1, 9'h000, 32'hE3E2E1E0, 1'b0, "b_wr_000");
      txn(1'b1, 1'b1, 1'b0, 9'h1FE, 32'h0,        1'b0, "b_rd_1fe");
      txn(1'b1, 1'b1, 1'b0, 9'h1F9, 32'h0,        1'b0, "b_rd_1f9");
      txn(1'b1, 1'b1, 1'b0, 9'h003, 32'h0,        1'b0, "b_rd_003");

      repeat (3) @(negedge clock);
      chk("a_queue_drained", 32'(q_a.size()), 32'd0);
      chk("b_queue_drained", 32'(q_b.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
